// File: rtl/wb_pkg.sv
// +-----------------------------------------------------------------------+
// | wb_pkg : shared constants and entry type for the write-back queue     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package wb_pkg;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         DEPTH_DEF = 4;
  localparam int         AW_DEF    = 5;
  localparam int         DW_DEF    = 32;

  typedef struct packed {
    logic [AW_DEF-1:0] wr;
    logic [DW_DEF-1:0] wd;
  } wb_entry_t;

endpackage

`default_nettype wire

// File: rtl/wbq_fwd_match.sv
// +-----------------------------------------------------------------------+
// | wbq_fwd_match : youngest-first forwarding lookup for one read port    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module wbq_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic [AW-1:0]    rr,
  input  logic [AW-1:0]    ent_wr  [DEPTH],
  input  logic [DW-1:0]    ent_wd  [DEPTH],
  input  logic [DEPTH-1:0] ent_vld,
  input  logic             out_vld,
  input  logic [AW-1:0]    out_wr,
  input  logic [DW-1:0]    out_wd,
  output logic             hit,
  output logic [DW-1:0]    data
);

  // Entries are age-ordered (index 0 = youngest); scanning oldest to
  // youngest lets the youngest match overwrite any older one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    if (rr != AW'(REG_ZERO)) begin
      if (out_vld && (out_wr == rr)) begin
        hit  = 1'b1;
        data = out_wd;
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (ent_vld[i] && (ent_wr[i] == rr)) begin
          hit  = 1'b1;
          data = ent_wd[i];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_write_queue.sv
// +-----------------------------------------------------------------------+
// | wb_write_queue : in-order register-file write FIFO with forwarding    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module wb_write_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_wr,
  input  logic [DW-1:0]            in_wd,
  output logic                     RegWrite,
  output logic [AW-1:0]            WR,
  output logic [DW-1:0]            WD,
  input  logic [AW-1:0]            fwd_rr1,
  input  logic [AW-1:0]            fwd_rr2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_data1,
  output logic [DW-1:0]            fwd_data2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] mem_wr_q [DEPTH];
  logic [DW-1:0] mem_wd_q [DEPTH];
  logic [AW-1:0] mem_wr_d [DEPTH];
  logic [DW-1:0] mem_wd_d [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [DW-1:0] wd_q, wd_d;

  logic accept;
  logic push;
  logic pop;

  assign in_ready = (count_q != CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  // Writes to r0 take a handshake beat but are dropped here.
  assign push     = accept && (in_wr != AW'(REG_ZERO));
  assign pop      = (count_q != '0);

  always_comb begin
    mem_wr_d = mem_wr_q;
    mem_wd_d = mem_wd_q;
    if (push) begin
      mem_wr_d[wr_ptr_q] = in_wr;
      mem_wd_d[wr_ptr_q] = in_wd;
    end
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    reg_write_d = pop;
    wr_d        = pop ? mem_wr_q[rd_ptr_q] : wr_q;
    wd_d        = pop ? mem_wd_q[rd_ptr_q] : wd_q;
  end

  // Storage has no reset: only entries covered by count are ever observed.
  always_ff @(posedge clk) begin
    mem_wr_q <= mem_wr_d;
    mem_wd_q <= mem_wd_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      reg_write_q <= 1'b0;
      wr_q        <= '0;
      wd_q        <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      reg_write_q <= reg_write_d;
      wr_q        <= wr_d;
      wd_q        <= wd_d;
    end
  end

  assign RegWrite = reg_write_q;
  assign WR       = wr_q;
  assign WD       = wd_q;
  assign count    = count_q;
  assign idle     = (count_q == '0) && !reg_write_q;

  logic [AW-1:0]    age_wr  [DEPTH];
  logic [DW-1:0]    age_wd  [DEPTH];
  logic [DEPTH-1:0] age_vld;

  // Age 0 is the entry just behind the tail pointer.
  for (genvar i = 0; i < DEPTH; i++) begin : g_age
    localparam logic [PW-1:0] OFF = PW'(i + 1);
    localparam logic [CW-1:0] AGE = CW'(i);
    logic [PW-1:0] idx;
    assign idx        = wr_ptr_q - OFF;
    assign age_wr[i]  = mem_wr_q[idx];
    assign age_wd[i]  = mem_wd_q[idx];
    assign age_vld[i] = (AGE < count_q);
  end

  wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
    .rr      (fwd_rr1),
    .ent_wr  (age_wr),
    .ent_wd  (age_wd),
    .ent_vld (age_vld),
    .out_vld (reg_write_q),
    .out_wr  (wr_q),
    .out_wd  (wd_q),
    .hit     (fwd_hit1),
    .data    (fwd_data1)
  );

  wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
    .rr      (fwd_rr2),
    .ent_wr  (age_wr),
    .ent_wd  (age_wd),
    .ent_vld (age_vld),
    .out_vld (reg_write_q),
    .out_wr  (wr_q),
    .out_wd  (wd_q),
    .hit     (fwd_hit2),
    .data    (fwd_data2)
  );

endmodule

`default_nettype wire

// File: tb/tb_wb_write_queue.sv
// +-----------------------------------------------------------------------+
// | tb_wb_write_queue : scoreboard bench for wb_write_queue               |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_wb_write_queue;
  import wb_pkg::*;

  localparam int DEPTH = DEPTH_DEF;
  localparam int AW    = AW_DEF;
  localparam int DW    = DW_DEF;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_wr;
  logic [DW-1:0] in_wd;
  logic          RegWrite;
  logic [AW-1:0] WR;
  logic [DW-1:0] WD;
  logic [AW-1:0] fwd_rr1, fwd_rr2;
  logic          fwd_hit1, fwd_hit2;
  logic [DW-1:0] fwd_data1, fwd_data2;
  logic [CW-1:0] count;
  logic          idle;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_wr     (in_wr),
    .in_wd     (in_wd),
    .RegWrite  (RegWrite),
    .WR        (WR),
    .WD        (WD),
    .fwd_rr1   (fwd_rr1),
    .fwd_rr2   (fwd_rr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count),
    .idle      (idle)
  );

  // Reference model: pending writes as a plain list plus the write port.
  wb_entry_t     m_fifo[$];
  wb_entry_t     exp_q[$];
  logic          m_out_v  = 1'b0;
  logic [AW-1:0] m_out_wr = '0;
  logic [DW-1:0] m_out_wd = '0;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_lookup(input logic [AW-1:0] rr, output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (rr != 0) begin
      for (int i = m_fifo.size() - 1; i >= 0; i--) begin
        if (!hit && m_fifo[i].wr == rr) begin
          hit  = 1'b1;
          data = m_fifo[i].wd;
        end
      end
      if (!hit && m_out_v && m_out_wr == rr) begin
        hit  = 1'b1;
        data = m_out_wd;
      end
    end
  endtask

  task automatic model_edge();
    wb_entry_t e;
    bit acc;
    if (!rst_n) begin
      m_fifo.delete();
      exp_q.delete();
      m_out_v  = 1'b0;
      m_out_wr = '0;
      m_out_wd = '0;
    end else begin
      acc = in_valid && (m_fifo.size() < DEPTH);
      if (m_fifo.size() > 0) begin
        e        = m_fifo.pop_front();
        m_out_v  = 1'b1;
        m_out_wr = e.wr;
        m_out_wd = e.wd;
      end else begin
        m_out_v = 1'b0;
      end
      if (acc && in_wr != 0) begin
        e.wr = in_wr;
        e.wd = in_wd;
        m_fifo.push_back(e);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [AW-1:0] wr,
                      input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    rst_n    = r;
    in_valid = v;
    in_wr    = wr;
    in_wd    = wd;
    fwd_rr1  = r1;
    fwd_rr2  = r2;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: state checks against the model, and in-order scoreboard on writes.
  initial begin
    logic          h;
    logic [DW-1:0] d;
    wb_entry_t     e;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        model_lookup(fwd_rr1, h, d);
        chk("fwd_hit1", 64'(fwd_hit1), 64'(h));
        chk("fwd_data1", 64'(fwd_data1), 64'(d));
        model_lookup(fwd_rr2, h, d);
        chk("fwd_hit2", 64'(fwd_hit2), 64'(h));
        chk("fwd_data2", 64'(fwd_data2), 64'(d));
        chk("count", 64'(count), 64'(m_fifo.size()));
        chk("in_ready", 64'(in_ready), 64'(m_fifo.size() < DEPTH));
        chk("idle", 64'(idle), 64'(m_fifo.size() == 0 && !m_out_v));
        chk("RegWrite", 64'(RegWrite), 64'(m_out_v));
        chk("WR", 64'(WR), 64'(m_out_wr));
        chk("WD", 64'(WD), 64'(m_out_wd));
        if (RegWrite === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_unexpected_write actual=WR %0h WD %0h required=no write at %0t", WR, WD, $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_WR", 64'(WR), 64'(e.wr));
            chk("sb_WD", 64'(WD), 64'(e.wd));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_wr = '0; in_wd = '0; fwd_rr1 = '0; fwd_rr2 = '0;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;
    chk("rst_RegWrite", 64'(RegWrite), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_count", 64'(count), 64'd0);

    // Single write
    step(1, 1, 1, 32'h12345678, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    chk("single_RegWrite", 64'(RegWrite), 64'd1);
    chk("single_WR", 64'(WR), 64'd1);
    chk("single_WD", 64'(WD), 64'h12345678);
    chk("single_fwd", 64'(fwd_data1), 64'h12345678);
    step(1, 0, 0, 0, 1, 0);
    chk("single_done", 64'(RegWrite), 64'd0);
    chk("single_idle", 64'(idle), 64'd1);

    // Back-to-back stream
    for (int i = 1; i <= 5; i++) step(1, 1, AW'(i), DW'(32'hA0 + i), AW'(i), 5);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

    // Forwarding priority
    step(1, 1, 3, 32'h11, 3, 3);
    step(1, 1, 3, 32'h22, 3, 3);
    chk("prio_hit1", 64'(fwd_hit1), 64'd1);
    chk("prio_data1", 64'(fwd_data1), 64'h22);
    step(1, 0, 0, 0, 3, 3);
    chk("prio_data_out", 64'(fwd_data1), 64'h22);
    step(1, 0, 0, 0, 3, 3);
    chk("prio_drained", 64'(fwd_hit1), 64'd0);

    // Register 0
    step(1, 1, 0, 32'hDEADBEEF, 0, 0);
    chk("r0_count", 64'(count), 64'd0);
    chk("r0_hit", 64'(fwd_hit1), 64'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("r0_nowrite", 64'(RegWrite), 64'd0);

    // Reset mid-drain
    for (int i = 0; i < 3; i++) step(1, 1, AW'(i + 6), DW'($urandom), 6, 7);
    step(0, 0, 0, 0, 6, 7);
    chk("rmid_RegWrite", 64'(RegWrite), 64'd0);
    chk("rmid_count", 64'(count), 64'd0);
    chk("rmid_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 6, 7);

    // Randomized traffic with gaps and occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 149) != 0), ($urandom_range(0, 99) < 70),
           AW'($urandom_range(0, 7)), DW'($urandom),
           AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end

    for (int i = 0; i < DEPTH + 3; i++) step(1, 0, 0, 0, 0, 0);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    chk("end_idle", 64'(idle), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
- Writer-side front end for the 32x32 register file.
- Accepts register write requests from execute/multi-cycle units over a valid/ready handshake and buffers them in an in-order FIFO.
- Drains one request per cycle onto the register file write port (RegWrite/WR/WD).
- Provides two forwarding lookups so decode reads see values still queued or in flight.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept; equals !full.
- in_wr  in  AW  destination register.
- in_wd  in  DW  write data.
- RegWrite  out  1  register file write enable; registered.
- WR  out  AW  register file write address; registered.
- WD  out  DW  register file write data; registered.
- fwd_rr1  in  AW  read address of decode port 1.
- fwd_rr2  in  AW  read address of decode port 2.
- fwd_hit1  out  1  pending write to fwd_rr1 exists.
- fwd_hit2  out  1  pending write to fwd_rr2 exists.
- fwd_data1  out  DW  youngest pending data for fwd_rr1; 0 when no hit.
- fwd_data2  out  DW  youngest pending data for fwd_rr2; 0 when no hit.
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the output stage.
- idle  out  1  count==0 && !RegWrite.

Behaviour:
- Clocking: one clock, clk. Reset rst_n is synchronous and active-low. Reset has priority over every other event in the same cycle.
- Reset values:
  - count=0, read/write pointers=0.
  - RegWrite=0, WR=0, WD=0.
  - in_ready=1, idle=1.
  - fwd_hit1/2=0, fwd_data1/2=0.
  - FIFO data contents are don't-care.
- Reset mid-operation: all queued and in-flight entries are discarded. RegWrite is 0 in the cycle after the reset edge. No partial write is issued.
- Enqueue: a request is accepted on a posedge where in_valid && in_ready. in_wr and in_wd are captured at the tail.
- Register 0: a request with in_wr==0 is handshaken normally (consumes the in_ready beat) but is not stored. It never reaches RegWrite and never forwards.
- Drain (output stage):
  - On each posedge, if count>0, the head is popped into WR/WD with RegWrite=1.
  - Otherwise RegWrite=0; WR/WD hold their previous values.
  - One entry per cycle; strict FIFO order.
- Latency: a request accepted at edge N into an empty queue appears with RegWrite=1 after edge N+1. The register file commits it at edge N+2. Throughput is 1 write/cycle sustained.
- Simultaneous push and pop: count unchanged; pointers both advance with wrap-around modulo DEPTH.
- Full: in_ready=0 whenever count==DEPTH, even if a pop occurs the same cycle (no same-cycle credit). in_valid with in_ready=0 is ignored; the producer holds its request.
- Empty: pop suppressed; the output stage deasserts RegWrite.
- Forwarding (combinational from current state):
  - Candidates are all valid FIFO entries plus the output stage when RegWrite=1.
  - Priority is youngest first: tail-1 … head, then the output stage.
  - fwd_rr==0 never hits.
  - An entry being enqueued in the current cycle is not visible until after the edge.
- Both forwarding ports are independent and may hit the same entry.

Decomposition:
- Shared package (wb_pkg) holds:
  - REG_ZERO=5'd0.
  - Defaults DEPTH_DEF=4, AW_DEF=5, DW_DEF=32.
  - A typedef for a queue entry: {wr[AW-1:0], wd[DW-1:0]}.
- One natural sub-module: wbq_fwd_match.
  - Combinational, youngest-first priority match of one read address against the entry array plus the output stage.
  - Instantiated twice, once per forwarding port.
- FIFO storage and pointer logic stay in wb_write_queue.

Test Plan:
- Single write: reset, then in_wr=1, in_wd=32'h12345678 accepted at edge 1 → RegWrite=1, WR=1, WD=32'h12345678 after edge 2; RegWrite=0 after edge 3; idle=1.
- Fill and backpressure: 5 back-to-back requests to regs 1..5 with the drain running → in_ready drops to 0 only if count reaches 4; all five emerge in order 1,2,3,4,5 on consecutive RegWrite cycles with no drops or duplicates.
- Forward priority: queue writes reg3=32'h11, then reg3=32'h22, with fwd_rr1=3 → fwd_hit1=1, fwd_data1=32'h22 while both are pending; after the second drains, fwd_hit1=0.
- Register 0: request in_wr=0, in_wd=32'hDEADBEEF → in_ready beat consumed; count stays 0; RegWrite never asserts; fwd_rr1=0 → fwd_hit1=0.
- Reset mid-drain: 3 entries queued, rst_n=0 for one edge → after the edge RegWrite=0, count=0, in_ready=1; no further writes reach the register file.
- Wrap-around: 12 requests with random gaps and simultaneous push/pop at count=2 → pointers wrap three times; the output sequence matches the input sequence exactly; count is never negative or above 4.
